// File: rtl/associate_pkg.sv
// Shared types and constants for the associate training sequencer.
package associate_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTFwd,
    StTRes,
    StTBwd,
    StTFbk,
    StCFwd,
    StCRes,
    StDone
  } state_e;

  localparam logic [15:0] DefHigh = 16'h00ff;
  localparam logic [15:0] DefLow  = 16'h0000;

  // Threshold activation: any non-negative result fires (selects HIGH).
  function automatic logic act_fires(input logic res_sign);
    return !res_sign;
  endfunction

endpackage

// File: rtl/associate_patterns.sv
// Argument/target pattern store: one write port, one asynchronous read port, no reset.
module associate_patterns #(
  parameter int unsigned NPAT    = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned ARGBITS = 16,
  parameter int unsigned RESW    = 16
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ARGBITS-1:0] i_warg,
  input  logic [RESW-1:0]    i_wtgt,
  input  logic [AW-1:0]      i_raddr,
  output logic [ARGBITS-1:0] o_rarg,
  output logic [RESW-1:0]    o_rtgt
);

  logic [ARGBITS-1:0] r_arg [NPAT];
  logic [RESW-1:0]    r_tgt [NPAT];

  always_ff @(posedge i_clk) begin
    if (i_we && (32'(i_waddr) < NPAT)) begin
      r_arg[i_waddr] <= i_warg;
      r_tgt[i_waddr] <= i_wtgt;
    end
  end

  assign o_rarg = r_arg[i_raddr];
  assign o_rtgt = r_tgt[i_raddr];

endmodule

// File: rtl/associate_trainer.sv
// Training sequencer for one associate unit: train epochs, then a learning-disabled
// check pass, until the check pass is error-free or the epoch limit is reached.
module associate_trainer
  import associate_pkg::*;
#(
  parameter int unsigned ARGW   = 8,
  parameter int unsigned ARGD   = 2,
  parameter int unsigned RESW   = 16,
  parameter int unsigned ERRW   = 16,
  parameter int unsigned FBKW   = 8,
  parameter int unsigned FBKD   = 2,
  parameter int unsigned NPAT   = 4,
  parameter int unsigned EPOCHS = 25,
  parameter logic [RESW-1:0] HIGH = RESW'(DefHigh),
  parameter logic [RESW-1:0] LOW  = RESW'(DefLow),
  localparam int unsigned AW = (NPAT > 1) ? $clog2(NPAT) : 1,
  localparam int unsigned EW = $clog2(EPOCHS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [AW-1:0]        ld_addr,
  input  logic [ARGD*ARGW-1:0] ld_arg,
  input  logic [RESW-1:0]      ld_tgt,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [EW-1:0]        epoch,
  output logic                 en,
  output logic                 arg_valid,
  input  logic                 arg_ready,
  output logic [ARGD*ARGW-1:0] arg_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [RESW-1:0]      res_data,
  output logic                 err_valid,
  input  logic                 err_ready,
  output logic [ERRW-1:0]      err_data,
  input  logic                 fbk_valid,
  output logic                 fbk_ready,
  input  logic [FBKD*FBKW-1:0] fbk_data
);

  localparam int unsigned MW = $clog2(NPAT + 1);
  localparam logic [AW-1:0] LastP    = AW'(NPAT - 1);
  localparam logic [EW-1:0] MaxEpoch = EW'(EPOCHS);

  state_e                r_state, w_state_d;
  logic [AW-1:0]         r_p, w_p_d;
  logic [EW-1:0]         r_epoch, w_epoch_d;
  logic [MW-1:0]         r_mis, w_mis_d, w_mis_inc;
  logic                  r_conv, w_conv_d;
  logic [ERRW-1:0]       r_err, w_err_d, w_err_calc;
  logic [RESW-1:0]       r_tgt_cur, w_tgt, w_act;
  logic [ARGD*ARGW-1:0]  r_arg_data, w_arg;
  logic                  w_last;

  logic r_ld_ready, r_busy, r_done, r_en, r_arg_valid, r_res_ready, r_err_valid, r_fbk_ready;
  logic w_ld_ready_d, w_busy_d, w_done_d, w_en_d;
  logic w_arg_valid_d, w_res_ready_d, w_err_valid_d, w_fbk_ready_d;

  // Feedback payload and result magnitude carry no information for this sequencer.
  logic w_unused;
  assign w_unused = ^{fbk_data, res_data[RESW-2:0]};

  // Read port follows the next pattern index so arg_data is ready with arg_valid.
  associate_patterns #(
    .NPAT    (NPAT),
    .AW      (AW),
    .ARGBITS (ARGD * ARGW),
    .RESW    (RESW)
  ) u_patterns (
    .i_clk   (clk),
    .i_we    (ld_valid & r_ld_ready),
    .i_waddr (ld_addr),
    .i_warg  (ld_arg),
    .i_wtgt  (ld_tgt),
    .i_raddr (w_p_d),
    .o_rarg  (w_arg),
    .o_rtgt  (w_tgt)
  );

  assign w_act      = act_fires(res_data[RESW-1]) ? HIGH : LOW;
  assign w_err_calc = ERRW'($signed(r_tgt_cur)) - ERRW'($signed(w_act));
  assign w_mis_inc  = r_mis + MW'(w_err_calc != '0);
  assign w_last     = (r_p == LastP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_p     <= '0;
      r_epoch <= '0;
      r_mis   <= '0;
      r_conv  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_d;
      r_p     <= w_p_d;
      r_epoch <= w_epoch_d;
      r_mis   <= w_mis_d;
      r_conv  <= w_conv_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_p_d     = r_p;
    w_epoch_d = r_epoch;
    w_mis_d   = r_mis;
    w_conv_d  = r_conv;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StTFwd;
          w_p_d     = '0;
          w_epoch_d = '0;
          w_mis_d   = '0;
          w_conv_d  = 1'b0;
        end
      end
      StTFwd: if (arg_ready) w_state_d = StTRes;
      StTRes: begin
        if (res_valid) begin
          w_err_d   = w_err_calc;
          w_state_d = StTBwd;
        end
      end
      StTBwd: if (err_ready) w_state_d = StTFbk;
      StTFbk: begin
        if (fbk_valid) begin
          if (w_last) begin
            w_p_d     = '0;
            w_epoch_d = r_epoch + 1'b1;
            w_state_d = StCFwd;
          end else begin
            w_p_d     = r_p + 1'b1;
            w_state_d = StTFwd;
          end
        end
      end
      StCFwd: if (arg_ready) w_state_d = StCRes;
      StCRes: begin
        if (res_valid) begin
          w_mis_d = w_mis_inc;
          if (!w_last) begin
            w_p_d     = r_p + 1'b1;
            w_state_d = StCFwd;
          end else if (w_mis_inc == '0) begin
            w_p_d     = '0;
            w_conv_d  = 1'b1;
            w_state_d = StDone;
          end else if (r_epoch == MaxEpoch) begin
            w_p_d     = '0;
            w_state_d = StDone;
          end else begin
            w_p_d     = '0;
            w_mis_d   = '0;
            w_state_d = StTFwd;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    w_ld_ready_d  = (w_state_d == StIdle);
    w_busy_d      = (w_state_d != StIdle);
    w_done_d      = (w_state_d == StDone);
    w_en_d        = (w_state_d inside {StTFwd, StTRes, StTBwd, StTFbk});
    w_arg_valid_d = (w_state_d inside {StTFwd, StCFwd});
    w_res_ready_d = (w_state_d inside {StTRes, StCRes});
    w_err_valid_d = (w_state_d == StTBwd);
    w_fbk_ready_d = (w_state_d == StTFbk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_en        <= 1'b0;
      r_arg_valid <= 1'b0;
      r_res_ready <= 1'b0;
      r_err_valid <= 1'b0;
      r_fbk_ready <= 1'b0;
      r_arg_data  <= '0;
      r_tgt_cur   <= '0;
    end else begin
      r_ld_ready  <= w_ld_ready_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_en        <= w_en_d;
      r_arg_valid <= w_arg_valid_d;
      r_res_ready <= w_res_ready_d;
      r_err_valid <= w_err_valid_d;
      r_fbk_ready <= w_fbk_ready_d;
      if (w_arg_valid_d) begin
        r_arg_data <= w_arg;
        r_tgt_cur  <= w_tgt;
      end
    end
  end

  assign ld_ready  = r_ld_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign converged = r_conv;
  assign epoch     = r_epoch;
  assign en        = r_en;
  assign arg_valid = r_arg_valid;
  assign arg_data  = r_arg_data;
  assign res_ready = r_res_ready;
  assign err_valid = r_err_valid;
  assign err_data  = r_err;
  assign fbk_ready = r_fbk_ready;

endmodule

// File: tb/tb_associate_trainer.sv
// Randomized bench for associate_trainer: a scripted unit responder plus a
// transaction-level model of the train/check schedule.
module tb_associate_trainer;

  localparam int unsigned ARGW = 8, ARGD = 2, RESW = 16, ERRW = 16;
  localparam int unsigned FBKW = 8, FBKD = 2, NPAT = 4, EPOCHS = 25;
  localparam int unsigned AW = 2, EW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [ARGD*ARGW-1:0] ld_arg;
  logic [RESW-1:0] ld_tgt;
  logic start, busy, done, converged, en;
  logic [EW-1:0] epoch;
  logic arg_valid, arg_ready, res_valid, res_ready;
  logic err_valid, err_ready, fbk_valid, fbk_ready;
  logic [ARGD*ARGW-1:0] arg_data;
  logic [RESW-1:0] res_data;
  logic [ERRW-1:0] err_data;
  logic [FBKD*FBKW-1:0] fbk_data;

  always #5 clk = ~clk;

  associate_trainer #(
    .ARGW(ARGW), .ARGD(ARGD), .RESW(RESW), .ERRW(ERRW),
    .FBKW(FBKW), .FBKD(FBKD), .NPAT(NPAT), .EPOCHS(EPOCHS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_arg(ld_arg),
    .ld_tgt(ld_tgt), .start(start), .busy(busy), .done(done), .converged(converged),
    .epoch(epoch), .en(en),
    .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .fbk_valid(fbk_valid), .fbk_ready(fbk_ready), .fbk_data(fbk_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] m_arg [NPAT];
  logic [15:0] m_tgt [NPAT];
  logic [15:0] m_err_q [$];
  logic [15:0] m_res_plan;
  bit m_train, m_finished, m_conv, m_have_res, seen_done;
  int m_idx, m_epoch, m_mis, m_passes, hold_cnt;
  bit arg_hold, err_hold;
  logic [15:0] arg_held, err_held;

  function automatic logic [15:0] ref_err(input logic [15:0] tgt, input logic [15:0] res);
    int act;
    act = ($signed(res) < 0) ? 0 : 255;
    return 16'(int'($signed(tgt)) - act);
  endfunction

  // Result the scripted unit returns in a check pass: hit or miss the target.
  function automatic logic [15:0] plan_res(input logic [15:0] tgt, input bit want_hit);
    logic [15:0] r;
    bit fire;
    r = 16'($urandom_range(16'h7fff));
    if (tgt == 16'h00ff) fire = want_hit;
    else if (tgt == 16'h0000) fire = !want_hit;
    else fire = 1'($urandom_range(1));
    return fire ? r : (r | 16'h8000);
  endfunction

  task automatic cycle_body(input int conv_at);
    logic [15:0] e;
    if (arg_hold) begin
      check_val("arg_hold_valid", 32'(arg_valid), 1);
      check_val("arg_hold_data", 32'(arg_data), 32'(arg_held));
    end
    if (err_hold) begin
      check_val("err_hold_valid", 32'(err_valid), 1);
      check_val("err_hold_data", 32'(err_data), 32'(err_held));
    end
    if (hold_cnt > 0 && arg_valid) begin
      arg_ready = 1'b0;
      hold_cnt--;
    end else arg_ready = ($urandom_range(3) != 0);
    if (res_ready) begin
      res_valid = m_have_res && ($urandom_range(2) != 0);
      res_data  = m_res_plan;
    end else begin
      res_valid = 1'($urandom_range(1));
      res_data  = 16'($urandom);
    end
    err_ready = ($urandom_range(2) != 0);
    fbk_valid = 1'($urandom_range(1));
    fbk_data  = 16'($urandom);
    arg_hold = arg_valid && !arg_ready;
    arg_held = arg_data;
    err_hold = err_valid && !err_ready;
    err_held = err_data;

    if (arg_valid && arg_ready) begin
      check_val("arg_unexpected", 32'(m_finished || m_have_res), 0);
      check_val("arg_data", 32'(arg_data), 32'(m_arg[m_idx]));
      check_val("arg_en", 32'(en), 32'(m_train));
      if (m_train) m_res_plan = 16'($urandom);
      else m_res_plan = plan_res(m_tgt[m_idx], (m_epoch >= conv_at) || (m_idx != m_epoch % NPAT));
      m_have_res = 1'b1;
    end
    if (res_valid && res_ready) begin
      check_val("res_expected", 32'(m_have_res), 1);
      m_have_res = 1'b0;
      e = ref_err(m_tgt[m_idx], res_data);
      if (m_train) m_err_q.push_back(e);
      else begin
        if (e != 0) m_mis++;
        m_idx++;
        if (m_idx == NPAT) begin
          m_idx = 0;
          m_passes++;
          if (m_mis == 0) begin
            m_finished = 1'b1;
            m_conv = 1'b1;
          end else if (m_epoch == EPOCHS) begin
            m_finished = 1'b1;
          end else begin
            m_train = 1'b1;
            m_mis = 0;
          end
        end
      end
    end
    if (err_valid && err_ready) begin
      check_val("err_en", 32'(en), 1);
      check_val("err_expected", m_err_q.size(), 1);
      if (m_err_q.size() > 0) check_val("err_data", 32'(err_data), 32'(m_err_q.pop_front()));
    end
    if (fbk_valid && fbk_ready) begin
      check_val("fbk_in_train", 32'(m_train), 1);
      m_idx++;
      if (m_idx == NPAT) begin
        m_idx = 0;
        m_epoch++;
        m_train = 1'b0;
      end
    end
    if (done) begin
      seen_done = 1'b1;
      check_val("done_expected", 32'(m_finished), 1);
      check_val("done_converged", 32'(converged), 32'(m_conv));
      check_val("done_epoch", 32'(epoch), 32'(m_epoch));
    end
  endtask

  task automatic run(input int conv_at, input int hold, input bit inject, input bit abort_bwd);
    m_train = 1'b1; m_finished = 1'b0; m_conv = 1'b0; m_have_res = 1'b0; seen_done = 1'b0;
    m_idx = 0; m_epoch = 0; m_mis = 0; m_passes = 0; hold_cnt = hold;
    arg_hold = 1'b0; err_hold = 1'b0;
    m_err_q.delete();
    @(negedge clk);
    check_val("idle_ld_ready", 32'(ld_ready), 1);
    start = 1'b1; arg_ready = 1'b0; res_valid = 1'b0; err_ready = 1'b0; fbk_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_val("start_arg_valid", 32'(arg_valid), 1);
    check_val("start_busy", 32'(busy), 1);
    check_val("start_epoch", 32'(epoch), 0);
    check_val("start_converged", 32'(converged), 0);
    for (int cyc = 0; cyc < 20000 && !seen_done; cyc++) begin
      start = 1'b0;
      ld_valid = 1'b0;
      if (abort_bwd && err_valid) begin
        rst_n = 1'b0;
        #1;
        check_val("abort_flags", 32'({ld_ready, busy, done, converged, epoch, en, arg_valid,
                                      res_ready, err_valid, fbk_ready}), 0);
        check_val("abort_data", {arg_data, err_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_ld_ready", 32'(ld_ready), 1);
        return;
      end
      cycle_body(conv_at);
      if (inject && cyc == 7) begin
        check_val("busy_ld_ready", 32'(ld_ready), 0);
        start = 1'b1;
        ld_valid = 1'b1;
        ld_addr = '0;
        ld_arg = ~m_arg[0];
        ld_tgt = ~m_tgt[0];
      end
      @(negedge clk);
    end
    start = 1'b0;
    ld_valid = 1'b0;
    check_val("done_seen", 32'(seen_done), 1);
    check_val("done_pulse", 32'(done), 0);
    check_val("idle_busy", 32'(busy), 0);
    check_val("hold_converged", 32'(converged), 32'(m_conv));
    check_val("hold_epoch", 32'(epoch), 32'(m_epoch));
  endtask

  task automatic load(input int a, input logic [15:0] arg, input logic [15:0] tgt);
    @(negedge clk);
    check_val("load_ready", 32'(ld_ready), 1);
    ld_valid = 1'b1;
    ld_addr = AW'(a);
    ld_arg = arg;
    ld_tgt = tgt;
    m_arg[a] = arg;
    m_tgt[a] = tgt;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_set(input logic [15:0] t0, input logic [15:0] t1,
                          input logic [15:0] t2, input logic [15:0] t3);
    load(0, 16'h0000, t0);
    load(1, 16'h00ff, t1);
    load(2, 16'hff00, t2);
    load(3, 16'hffff, t3);
  endtask

  int k;

  initial begin
    ld_valid = 1'b0; ld_addr = '0; ld_arg = '0; ld_tgt = '0; start = 1'b0;
    arg_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    err_ready = 1'b0; fbk_valid = 1'b0; fbk_data = '0;
    repeat (3) @(negedge clk);
    check_val("reset_flags", 32'({ld_ready, busy, done, converged, epoch, en, arg_valid,
                                  res_ready, err_valid, fbk_ready}), 0);
    check_val("reset_data", {arg_data, err_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_ld_ready", 32'(ld_ready), 1);

    // OR
    load_set(16'h0000, 16'h00ff, 16'h00ff, 16'h00ff);
    run(int'($urandom_range(1, 5)), 0, 1'b0, 1'b0);
    check_val("or_converged", 32'(converged), 1);

    // AND with arg backpressure and start/load while busy
    load_set(16'h0000, 16'h0000, 16'h0000, 16'h00ff);
    k = int'($urandom_range(2, 6));
    run(k, 5, 1'b1, 1'b0);
    check_val("and_converged", 32'(converged), 1);
    check_val("and_epoch", 32'(epoch), 32'(k));

    // Abort in T_BWD, then rerun AND without reloading
    run(3, 0, 1'b0, 1'b1);
    k = int'($urandom_range(1, 6));
    run(k, 0, 1'b0, 1'b0);
    check_val("restart_converged", 32'(converged), 1);
    check_val("restart_epoch", 32'(epoch), 32'(k));

    // XOR never converges
    load_set(16'h0000, 16'h00ff, 16'h00ff, 16'h0000);
    run(1000, 0, 1'b0, 1'b0);
    check_val("xor_converged", 32'(converged), 0);
    check_val("xor_epoch", 32'(epoch), 25);
    check_val("xor_passes", 32'(m_passes), 25);

    // Random args, targets mixing binary levels and arbitrary values
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < NPAT; a++) begin
        logic [15:0] t;
        case ($urandom_range(2))
          0: t = 16'h0000;
          1: t = 16'h00ff;
          default: t = 16'($urandom);
        endcase
        load(a, 16'($urandom), t);
      end
      run(int'($urandom_range(1, 30)), int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/associate_trainer.md
# associate_trainer

Training sequencer for one `associate` unit. Holds a small set of argument/target patterns and drives the unit's forward and backward handshakes epoch by epoch. After each training epoch it runs a check pass with learning disabled and stops early on zero error, or stops after `EPOCHS` epochs. It replaces bench-side training loops and sits between the configuration/host side and the `associate` datapath.

## Interface
- `ARGW` = 8: argument element width.
- `ARGD` = 2: argument elements per pattern.
- `RESW` = 16: result width from the unit.
- `ERRW` = 16: error width sent to the unit.
- `FBKW` = 8, `FBKD` = 2: feedback element width and depth.
  - Feedback data is consumed and discarded.
- `NPAT` = 4: number of stored patterns, ≥ 1.
- `EPOCHS` = 25: maximum training epochs, ≥ 1.
- `HIGH` = 16'h00ff, `LOW` = 16'h0000: threshold activation levels (RESW bits).

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld_valid` in 1, `ld_ready` out 1: pattern load handshake.
- `ld_addr` in $clog2(NPAT), `ld_arg` in ARGD×ARGW, `ld_tgt` in RESW: pattern write data.
- `start` in 1: single-cycle request to begin training.
- `busy`, `done`, `converged` out 1: status.
- `epoch` out $clog2(EPOCHS+1): number of training epochs completed.
- `en` out 1: learning enable to the unit.
- `arg_valid` out 1, `arg_ready` in 1, `arg_data` out ARGD×ARGW: forward argument stream.
- `res_valid` in 1, `res_ready` out 1, `res_data` in RESW: forward result stream.
- `err_valid` out 1, `err_ready` in 1, `err_data` out ERRW: backward error stream.
- `fbk_valid` in 1, `fbk_ready` out 1, `fbk_data` in FBKD×FBKW: feedback stream.

## Operation
- **Handshake rule:** a transfer occurs when valid && ready on a rising `clk`. Once asserted, a valid and its data stay stable until the transfer completes.
- **Loading:** `ld_ready`=1 only in IDLE. A load transfer writes `ld_arg`/`ld_tgt` at `ld_addr`. Pattern storage is not cleared by reset.
- **Start:** `start` in IDLE clears `epoch`, `done` and `converged`, sets pattern index p=0, and enters T_FWD. `start` in any other state is ignored.
- **Training states (`en`=1):**
  - T_FWD: `arg_valid`=1, `arg_data`=arg[p]. On transfer, go to T_RES.
  - T_RES: `res_ready`=1. On transfer, register err = tgt[p] − act, where act = ($signed(res_data) < 0) ? LOW : HIGH. Both operands are sign-extended to ERRW before subtracting. Go to T_BWD.
  - T_BWD: `err_valid`=1. On transfer, go to T_FBK.
  - T_FBK: `fbk_ready`=1. On transfer, if p==NPAT−1 then p=0, `epoch`++ and go to C_FWD. Otherwise p++ and go to T_FWD.
- **Check states (`en`=0):**
  - C_FWD and C_RES: same handshakes as training. Each nonzero error increments a mismatch counter; no backward pass is issued.
  - After the check result for p==NPAT−1:
    - mismatches==0: go to DONE with `converged`=1.
    - else `epoch`==EPOCHS: go to DONE with `converged`=0.
    - otherwise: clear the mismatch count, p=0, go to T_FWD.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. `converged` and `epoch` hold until the next accepted `start`.
- **`busy`:** 1 in every state except IDLE.

## Timing
- **Reset values:** every output is 0: `ld_ready`, `busy`, `done`, `converged`, `epoch`, `en`, all valids/readies, `arg_data`, `err_data`. State is IDLE.
  - `ld_ready` rises the first cycle after reset deasserts.
- **Registered outputs:** all outputs come from registers. No combinational path from any ready/valid input to any output.
- **Per-pattern cost with a zero-wait unit:** 4 cycles for training, 2 cycles for check.
  - `arg_valid` is asserted the cycle after `start` is accepted.
- **Reset mid-operation:** asserting `rst_n` low mid-operation aborts immediately to IDLE. No partial transfer is completed and stored patterns survive.
- **Back-to-back transfers:** a valid deasserts the cycle after its transfer unless the next state re-asserts it. T_FBK→T_FWD always inserts one cycle.
- **Ignored inputs:** `res_valid`/`fbk_valid` outside their wait states are ignored, not buffered.

## Structure
- **`associate_pkg`:** holds the state enum (IDLE, T_FWD, T_RES, T_BWD, T_FBK, C_FWD, C_RES, DONE), the default `HIGH`/`LOW` constants and the activation function.
- **`associate_patterns` sub-module:** an NPAT-entry register file with one write port and one asynchronous read port on p. No reset.
- **Top level:** FSM, counters and the error register.

## Test plan
- **AND:** NPAT=4, args {0000, 00ff, ff00, ffff}, tgts {0, 0, 0, 00ff}, `start`, paired with `associate` (RATE=1) → `done` pulse with `converged`=1, `epoch` ≤ 25.
- **OR:** args as for AND, tgts {0, 00ff, 00ff, 00ff} → `converged`=1; a bench replay of all four patterns with `en`=0 gives err=0.
- **XOR:** tgts {0, 00ff, 00ff, 0} → `done` with `converged`=0 and `epoch`=25, after exactly 25 check passes.
- **Backpressure:** hold `arg_ready`=0 for 5 cycles, and `err_ready`/`fbk_valid` low at random → `arg_data`/`err_data` stay stable while their valid is high, and there is exactly one `en`-high backward transfer per forward transfer.
- **Reset and restart:** pulse `rst_n` low during T_BWD → next cycle all outputs are 0 and state is IDLE; a new `start` without reloading reproduces the AND result.
  - `start` and `ld_valid` while `busy` → `start` ignored, `ld_ready`=0, pattern unchanged.
